// File: rtl/branch_predict_unit_if.sv
// Predictor bus between the D/E pipeline stages and branch_predict_unit.
// master = pipeline side, slave = predictor side.
interface branch_predict_unit_if #(
   parameter int GHR_BITS = 8
);
   logic                stall;
   logic                pred_valid_i;
   logic [31:0]         pred_pc_i;
   logic                pred_take_o;
   logic [GHR_BITS-1:0] pred_ghr_o;
   logic                upd_valid_i;
   logic [31:0]         upd_pc_i;
   logic [GHR_BITS-1:0] upd_ghr_i;
   logic                upd_taken_i;
   logic                upd_mispred_i;
   logic [31:0]         perf_br_o;
   logic [31:0]         perf_miss_o;

   modport master (
      output stall, pred_valid_i, pred_pc_i,
      output upd_valid_i, upd_pc_i, upd_ghr_i,
      output upd_taken_i, upd_mispred_i,
      input  pred_take_o, pred_ghr_o,
      input  perf_br_o, perf_miss_o
   );

   modport slave (
      input  stall, pred_valid_i, pred_pc_i,
      input  upd_valid_i, upd_pc_i, upd_ghr_i,
      input  upd_taken_i, upd_mispred_i,
      output pred_take_o, pred_ghr_o,
      output perf_br_o, perf_miss_o
   );
endinterface

// File: rtl/branch_predict_unit.sv
// Dynamic branch predictor: PHT of saturating counters, bimodal or gshare.
// Predicts in D, repairs speculative GHR and trains PHT at E resolution.
module branch_predict_unit #(
   parameter int PHT_DEPTH = 256,
   parameter int CNT_BITS  = 2,
   parameter int GHR_BITS  = 8,
   parameter int MODE      = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   branch_predict_unit_if.slave bus
);
   localparam int IDX_W = $clog2(PHT_DEPTH);
   localparam logic [CNT_BITS-1:0] CNT_INIT = CNT_BITS'((1 << (CNT_BITS-1)) - 1);
   localparam logic [CNT_BITS-1:0] CNT_MAX  = '1;

   logic [CNT_BITS-1:0] r_pht [PHT_DEPTH];
   logic [GHR_BITS-1:0] r_ghr;
   logic [31:0]         r_br;
   logic [31:0]         r_miss;

   logic [IDX_W-1:0]    w_ppc_idx;
   logic [IDX_W-1:0]    w_upc_idx;
   logic [IDX_W-1:0]    w_pidx;
   logic [IDX_W-1:0]    w_uidx;
   logic [CNT_BITS-1:0] w_cnt_pred;
   logic [CNT_BITS-1:0] w_cnt_upd;
   logic [CNT_BITS-1:0] w_cnt_nxt;
   logic [GHR_BITS-1:0] w_ghr_spec;
   logic [GHR_BITS-1:0] w_ghr_fix;
   logic                w_repair;
   logic                w_spec;
   logic                w_unused;

   assign w_ppc_idx = bus.pred_pc_i[IDX_W+1:2];
   assign w_upc_idx = bus.upd_pc_i[IDX_W+1:2];

   // Lookup hashes the live GHR; training hashes the snapshot carried down the pipe.
   assign w_pidx = (MODE == 1) ? (w_ppc_idx ^ IDX_W'(r_ghr)) : w_ppc_idx;
   assign w_uidx = (MODE == 1) ? (w_upc_idx ^ IDX_W'(bus.upd_ghr_i)) : w_upc_idx;

   assign w_cnt_pred      = r_pht[w_pidx];
   assign w_cnt_upd       = r_pht[w_uidx];
   assign bus.pred_take_o = w_cnt_pred[CNT_BITS-1];
   assign bus.pred_ghr_o  = r_ghr;
   assign bus.perf_br_o   = r_br;
   assign bus.perf_miss_o = r_miss;

   assign w_repair = bus.upd_valid_i & bus.upd_mispred_i;
   assign w_spec   = bus.pred_valid_i & ~bus.stall & ~w_repair;

   generate
      if (GHR_BITS == 1) begin : g_ghr1
         assign w_ghr_spec = bus.pred_take_o;
         assign w_ghr_fix  = bus.upd_taken_i;
      end else begin : g_ghrn
         assign w_ghr_spec = {r_ghr[GHR_BITS-2:0], bus.pred_take_o};
         assign w_ghr_fix  = {bus.upd_ghr_i[GHR_BITS-2:0], bus.upd_taken_i};
      end
   endgenerate

   assign w_unused = ^{bus.pred_pc_i, bus.upd_pc_i, bus.upd_ghr_i};

   // Saturating counter step for the resolved branch.
   always_comb begin
      w_cnt_nxt = w_cnt_upd;
      if (bus.upd_taken_i) begin
         if (w_cnt_upd != CNT_MAX) w_cnt_nxt = w_cnt_upd + 1'b1;
      end else begin
         if (w_cnt_upd != '0) w_cnt_nxt = w_cnt_upd - 1'b1;
      end
   end

   // PHT write port; same-cycle lookups still see the old entry.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < PHT_DEPTH; i++) r_pht[i] <= CNT_INIT;
      end else if (bus.upd_valid_i) begin
         r_pht[w_uidx] <= w_cnt_nxt;
      end
   end

   // GHR: repair from the flushed branch beats a speculative shift.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ghr <= '0;
      end else if (w_repair) begin
         r_ghr <= w_ghr_fix;
      end else if (w_spec) begin
         r_ghr <= w_ghr_spec;
      end
   end

   // Perf counters, free-running and wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_br   <= '0;
         r_miss <= '0;
      end else if (bus.upd_valid_i) begin
         r_br <= r_br + 32'd1;
         if (bus.upd_mispred_i) r_miss <= r_miss + 32'd1;
      end
   end
endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed bench for branch_predict_unit.
// u0 runs bimodal, u1 runs gshare; both share clk/rst.
module tb_branch_predict_unit;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_tot = 0;
   int   n_bad = 0;

   branch_predict_unit_if #(.GHR_BITS(8)) if0 ();
   branch_predict_unit_if #(.GHR_BITS(8)) if1 ();

   branch_predict_unit #(
      .PHT_DEPTH(256), .CNT_BITS(2), .GHR_BITS(8), .MODE(0)
   ) u0 (
      .clk(clk), .rst(rst), .bus(if0.slave)
   );

   branch_predict_unit #(
      .PHT_DEPTH(256), .CNT_BITS(2), .GHR_BITS(8), .MODE(1)
   ) u1 (
      .clk(clk), .rst(rst), .bus(if1.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_tot++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic upd0(input logic [31:0] pc, input logic tk,
                       input logic mis);
      if0.upd_pc_i      = pc;
      if0.upd_taken_i   = tk;
      if0.upd_mispred_i = mis;
      if0.upd_valid_i   = 1'b1;
      tick();
      if0.upd_valid_i   = 1'b0;
      if0.upd_mispred_i = 1'b0;
      #1;
   endtask

   task automatic upd1(input logic [31:0] pc, input logic [7:0] g,
                       input logic tk, input logic mis);
      if1.upd_pc_i      = pc;
      if1.upd_ghr_i     = g;
      if1.upd_taken_i   = tk;
      if1.upd_mispred_i = mis;
      if1.upd_valid_i   = 1'b1;
      tick();
      if1.upd_valid_i   = 1'b0;
      if1.upd_mispred_i = 1'b0;
      #1;
   endtask

   initial begin
      if0.stall = 0; if0.pred_valid_i = 0; if0.pred_pc_i = 0;
      if0.upd_valid_i = 0; if0.upd_pc_i = 0; if0.upd_ghr_i = 0;
      if0.upd_taken_i = 0; if0.upd_mispred_i = 0;
      if1.stall = 0; if1.pred_valid_i = 0; if1.pred_pc_i = 0;
      if1.upd_valid_i = 0; if1.upd_pc_i = 0; if1.upd_ghr_i = 0;
      if1.upd_taken_i = 0; if1.upd_mispred_i = 0;

      // reset state
      #1 rst = 1'b1;
      if0.pred_pc_i = 32'hBFC0_0000;
      #1;
      chk("rst_pred_a", 32'(if0.pred_take_o), 32'd0);
      chk("rst_ghr", 32'(if0.pred_ghr_o), 32'd0);
      if0.pred_pc_i = 32'hBFC0_0FFC;
      #1;
      chk("rst_pred_b", 32'(if0.pred_take_o), 32'd0);
      chk("rst_br", if0.perf_br_o, 32'd0);
      chk("rst_miss", if0.perf_miss_o, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // bimodal training 01->10->11
      if0.pred_pc_i = 32'hBFC0_0100;
      #1;
      chk("m0_init", 32'(if0.pred_take_o), 32'd0);
      upd0(32'hBFC0_0100, 1'b1, 1'b1);
      chk("m0_t1", 32'(if0.pred_take_o), 32'd1);
      upd0(32'hBFC0_0100, 1'b1, 1'b0);
      chk("m0_t2", 32'(if0.pred_take_o), 32'd1);
      chk("m0_br", if0.perf_br_o, 32'd2);
      chk("m0_miss", if0.perf_miss_o, 32'd1);

      // mispred without valid must be ignored
      if0.upd_mispred_i = 1'b1;
      tick();
      if0.upd_mispred_i = 1'b0;
      chk("m0_miss_nv", if0.perf_miss_o, 32'd1);

      // saturation both ends
      repeat (6) upd0(32'hBFC0_0100, 1'b1, 1'b0);
      chk("sat_hi", 32'(if0.pred_take_o), 32'd1);
      upd0(32'hBFC0_0100, 1'b0, 1'b0);
      chk("sat_hi_dec", 32'(if0.pred_take_o), 32'd1);
      repeat (4) upd0(32'hBFC0_0100, 1'b0, 1'b0);
      chk("sat_lo", 32'(if0.pred_take_o), 32'd0);
      chk("sat_br", if0.perf_br_o, 32'd13);
      upd0(32'hBFC0_0100, 1'b1, 1'b0);
      chk("sat_lo_inc", 32'(if0.pred_take_o), 32'd0);
      upd0(32'hBFC0_0100, 1'b1, 1'b0);
      chk("sat_lo_inc2", 32'(if0.pred_take_o), 32'd1);

      // async reset mid-sequence, checked before next edge
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("ar_pred", 32'(if0.pred_take_o), 32'd0);
      chk("ar_br", if0.perf_br_o, 32'd0);
      chk("ar_miss", if0.perf_miss_o, 32'd0);
      chk("ar_ghr", 32'(if0.pred_ghr_o), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("ar_hold", 32'(if0.pred_take_o), 32'd0);

      // gshare: load GHR=A5 via repair (0x52 shifted + taken)
      if1.pred_pc_i = 32'h0000_0000;
      upd1(32'h0000_0000, 8'h52, 1'b1, 1'b1);
      chk("g_ghr_a5", 32'(if1.pred_ghr_o), 32'hA5);
      chk("g_pred_a5", 32'(if1.pred_take_o), 32'd0);
      if1.stall = 1'b1;
      if1.pred_valid_i = 1'b1;
      tick();
      chk("g_stall", 32'(if1.pred_ghr_o), 32'hA5);
      if1.stall = 1'b0;
      tick();
      if1.pred_valid_i = 1'b0;
      chk("g_shift", 32'(if1.pred_ghr_o), 32'h4A);

      // same-cycle repair vs shift; lookup and update hit idx 0x30
      if1.pred_pc_i     = 32'h0000_01E8;
      if1.pred_valid_i  = 1'b1;
      if1.upd_pc_i      = 32'h0000_00FC;
      if1.upd_ghr_i     = 8'h0F;
      if1.upd_taken_i   = 1'b1;
      if1.upd_mispred_i = 1'b1;
      if1.upd_valid_i   = 1'b1;
      #1;
      chk("sc_old", 32'(if1.pred_take_o), 32'd0);
      tick();
      if1.pred_valid_i  = 1'b0;
      if1.upd_valid_i   = 1'b0;
      if1.upd_mispred_i = 1'b0;
      chk("sc_repair", 32'(if1.pred_ghr_o), 32'h1F);
      if1.pred_pc_i = 32'h0000_00BC;
      #1;
      chk("sc_new", 32'(if1.pred_take_o), 32'd1);
      chk("g_br", if1.perf_br_o, 32'd2);
      chk("g_miss", if1.perf_miss_o, 32'd2);

      $display("test done: total=%0d bad=%0d", n_tot, n_bad);
      $finish;
   end
endmodule
